// File: rtl/io_bus_exerciser.sv
// Host-side driver for an 8-bit pin-level DUT interface: steps the pin clock and pin reset
// on command and returns each sampled DUT output byte over a valid/ready response port.
module io_bus_exerciser #(
   parameter int unsigned DIV         = 4,
   parameter int unsigned RST_PERIODS = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_sel,
   input  logic [2:0] cmd_stim,
   input  logic [7:0] cmd_count,
   input  logic       cmd_reset,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic       rsp_last,
   output logic       busy,
   output logic [7:0] pin_out,
   input  logic [7:0] pin_in
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST_LO,
      S_RST_HI,
      S_CLK_LO,
      S_CLK_HI,
      S_RESP
   } state_t;

   localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
   localparam logic [3:0] PER_LAST = 4'(RST_PERIODS - 1);

   state_t     state_q, state_d;
   logic [7:0] div_q, div_d;
   logic [3:0] per_q, per_d;
   logic [8:0] remain_q, remain_d;
   logic [2:0] sel_q, sel_d;
   logic [2:0] stim_q, stim_d;
   logic       pin_clk_q, pin_clk_d;
   logic       pin_rstn_q, pin_rstn_d;
   logic [7:0] rsp_data_q, rsp_data_d;
   logic       rsp_last_q, rsp_last_d;
   logic [7:0] sync1_q, sync2_q;
   logic       phase_done;

   assign phase_done = (div_q == DIV_LAST);

   // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      per_d      = per_q;
      remain_d   = remain_q;
      sel_d      = sel_q;
      stim_d     = stim_q;
      pin_clk_d  = pin_clk_q;
      pin_rstn_d = pin_rstn_q;
      rsp_data_d = rsp_data_q;
      rsp_last_d = rsp_last_q;

      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               sel_d    = cmd_sel;
               stim_d   = cmd_stim;
               remain_d = (cmd_count == 8'd0) ? 9'd256 : {1'b0, cmd_count};
               div_d    = 8'd0;
               if (cmd_reset) begin
                  per_d      = 4'd0;
                  pin_rstn_d = 1'b0;
                  state_d    = S_RST_LO;
               end else begin
                  state_d = S_CLK_LO;
               end
            end
         end
         S_RST_LO: begin
            div_d = div_q + 8'd1;
            if (phase_done) begin
               div_d     = 8'd0;
               pin_clk_d = 1'b1;
               state_d   = S_RST_HI;
            end
         end
         S_RST_HI: begin
            div_d = div_q + 8'd1;
            if (phase_done) begin
               div_d     = 8'd0;
               pin_clk_d = 1'b0;
               if (per_q == PER_LAST) begin
                  pin_rstn_d = 1'b1;
                  state_d    = S_CLK_LO;
               end else begin
                  per_d   = per_q + 4'd1;
                  state_d = S_RST_LO;
               end
            end
         end
         S_CLK_LO: begin
            div_d = div_q + 8'd1;
            if (phase_done) begin
               div_d     = 8'd0;
               pin_clk_d = 1'b1;
               state_d   = S_CLK_HI;
            end
         end
         S_CLK_HI: begin
            div_d = div_q + 8'd1;
            if (phase_done) begin
               div_d      = 8'd0;
               rsp_data_d = sync2_q;
               rsp_last_d = (remain_q == 9'd1);
               state_d    = S_RESP;
            end
         end
         S_RESP: begin
            // The pin clock stays high until the response is taken.
            if (rsp_ready) begin
               remain_d  = remain_q - 9'd1;
               pin_clk_d = 1'b0;
               state_d   = (remain_q == 9'd1) ? S_IDLE : S_CLK_LO;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         div_q      <= 8'd0;
         per_q      <= 4'd0;
         remain_q   <= 9'd0;
         sel_q      <= 3'd0;
         stim_q     <= 3'd0;
         pin_clk_q  <= 1'b0;
         pin_rstn_q <= 1'b0;
         rsp_data_q <= 8'd0;
         rsp_last_q <= 1'b0;
         sync1_q    <= 8'd0;
         sync2_q    <= 8'd0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         per_q      <= per_d;
         remain_q   <= remain_d;
         sel_q      <= sel_d;
         stim_q     <= stim_d;
         pin_clk_q  <= pin_clk_d;
         pin_rstn_q <= pin_rstn_d;
         rsp_data_q <= rsp_data_d;
         rsp_last_q <= rsp_last_d;
         sync1_q    <= pin_in;
         sync2_q    <= sync1_q;
      end
   end

   assign cmd_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign rsp_valid = (state_q == S_RESP);
   assign rsp_data  = rsp_data_q;
   assign rsp_last  = rsp_last_q;
   assign pin_out   = {sel_q, stim_q, pin_rstn_q, pin_clk_q};

endmodule

// File: tb/tb_io_bus_exerciser.sv
// Directed bench for io_bus_exerciser; the DUT behind the pins is modelled as a counter
// cleared by pin reset_n and advanced on each rising pin clock.
module tb_io_bus_exerciser;

   localparam int unsigned DIV         = 4;
   localparam int unsigned RST_PERIODS = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [2:0] cmd_sel = 3'd0;
   logic [2:0] cmd_stim = 3'd0;
   logic [7:0] cmd_count = 8'd0;
   logic       cmd_reset = 1'b0;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [7:0] rsp_data;
   logic       rsp_last;
   logic       busy;
   logic [7:0] pin_out;
   logic [7:0] pin_in;
   logic [7:0] model_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   io_bus_exerciser #(.DIV(DIV), .RST_PERIODS(RST_PERIODS)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_sel   (cmd_sel),
      .cmd_stim  (cmd_stim),
      .cmd_count (cmd_count),
      .cmd_reset (cmd_reset),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_last  (rsp_last),
      .busy      (busy),
      .pin_out   (pin_out),
      .pin_in    (pin_in)
   );

   always #5 clk = ~clk;

   always @(posedge pin_out[0] or negedge pin_out[1] or posedge reset) begin
      if (reset || !pin_out[1]) model_cnt <= 8'd0;
      else                      model_cnt <= model_cnt + 8'd1;
   end
   assign pin_in = model_cnt;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic send_cmd(input logic [2:0] sel, input logic [2:0] stim,
                           input logic [7:0] count, input logic rst_seq);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_sel   = sel;
      cmd_stim  = stim;
      cmd_count = count;
      cmd_reset = rst_seq;
      n_checks++;
      if (cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL cmd_ready_at_issue: got %b expected 1", cmd_ready);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      n_checks++;
      if (pin_out[7:2] !== {sel, stim}) begin
         n_fail++;
         $display("FAIL pin_sel_stim: got %b expected %b", pin_out[7:2], {sel, stim});
      end
   endtask

   // Waits for rsp_valid (rsp_ready assumed high), checks wait length, data, last and the one-cycle pulse.
   task automatic get_rsp(input logic [7:0] exp_data, input logic exp_last, input int exp_wait,
                          input string name);
      int n;
      n = 0;
      while (rsp_valid !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (n !== exp_wait) begin
         n_fail++;
         $display("FAIL %s wait: got %0d cycles expected %0d", name, n, exp_wait);
      end
      n_checks++;
      if (rsp_data !== exp_data) begin
         n_fail++;
         $display("FAIL %s data: got %h expected %h", name, rsp_data, exp_data);
      end
      n_checks++;
      if (rsp_last !== exp_last) begin
         n_fail++;
         $display("FAIL %s last: got %b expected %b", name, rsp_last, exp_last);
      end
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s pulse: rsp_valid got %b expected 0", name, rsp_valid);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      n_checks++;
      if (pin_out !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_pin_out: got %h expected 00", pin_out);
      end
      n_checks++;
      if ({cmd_ready, busy, rsp_valid, rsp_last} !== 4'b1000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected 1000", {cmd_ready, busy, rsp_valid, rsp_last});
      end
      n_checks++;
      if (rsp_data !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_rsp_data: got %h expected 00", rsp_data);
      end
   endtask

   task automatic test_reset_sequence;
      int k;
      rsp_ready = 1'b1;
      send_cmd(3'd5, 3'd3, 8'd3, 1'b1);
      n_checks++;
      if (pin_out[7:2] !== 6'b101011) begin
         n_fail++;
         $display("FAIL seq_pin_bits: got %b expected 101011", pin_out[7:2]);
      end
      k = 0;
      while (pin_out[1] === 1'b0 && k < 100) begin
         k++;
         @(negedge clk);
      end
      n_checks++;
      if (k !== 16) begin
         n_fail++;
         $display("FAIL seq_rstn_low: got %0d cycles expected 16", k);
      end
      n_checks++;
      if (model_cnt !== 8'h00) begin
         n_fail++;
         $display("FAIL seq_model_cleared: got %h expected 00", model_cnt);
      end
      get_rsp(8'h01, 1'b0, 8, "seq_rsp1");
      get_rsp(8'h02, 1'b0, 8, "seq_rsp2");
      get_rsp(8'h03, 1'b1, 8, "seq_rsp3");
      n_checks++;
      if ({cmd_ready, busy, pin_out[0]} !== 3'b100) begin
         n_fail++;
         $display("FAIL seq_idle_after: got %b expected 100", {cmd_ready, busy, pin_out[0]});
      end
   endtask

   task automatic test_back_pressure_and_256;
      int n;
      rsp_ready = 1'b0;
      send_cmd(3'd1, 3'd6, 8'd0, 1'b0);
      n = 0;
      while (rsp_valid !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (n !== 8) begin
         n_fail++;
         $display("FAIL bp_first_latency: got %0d expected 8", n);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_checks++;
         if ({rsp_valid, pin_out[0], rsp_last, rsp_data, model_cnt} !== {3'b110, 8'h04, 8'h04}) begin
            n_fail++;
            $display("FAIL bp_hold cycle %0d: got valid=%b clk=%b last=%b data=%h model=%h expected 1 1 0 04 04",
                     i, rsp_valid, pin_out[0], rsp_last, rsp_data, model_cnt);
         end
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_release: rsp_valid got %b expected 0", rsp_valid);
      end
      for (int i = 1; i < 256; i++) begin
         get_rsp(8'(4 + i), (i == 255), 8, $sformatf("run256_rsp%0d", i));
      end
      n_checks++;
      if ({cmd_ready, busy, pin_out[0]} !== 3'b100) begin
         n_fail++;
         $display("FAIL run256_idle_after: got %b expected 100", {cmd_ready, busy, pin_out[0]});
      end
   endtask

   task automatic test_async_reset;
      int n;
      rsp_ready = 1'b1;
      send_cmd(3'd3, 3'd2, 8'd5, 1'b0);
      get_rsp(8'h04, 1'b0, 8, "mid_rsp1");
      get_rsp(8'h05, 1'b0, 8, "mid_rsp2");
      rsp_ready = 1'b0;
      n = 0;
      while (rsp_valid !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (n !== 8) begin
         n_fail++;
         $display("FAIL mid_rsp3_wait: got %0d expected 8", n);
      end
      #1 reset = 1'b1;
      #1;
      n_checks++;
      if (pin_out !== 8'h00) begin
         n_fail++;
         $display("FAIL mid_reset_pin_out: got %h expected 00", pin_out);
      end
      n_checks++;
      if ({rsp_valid, cmd_ready, busy, rsp_last, rsp_data} !== {4'b0100, 8'h00}) begin
         n_fail++;
         $display("FAIL mid_reset_outputs: got valid=%b ready=%b busy=%b last=%b data=%h expected 0 1 0 0 00",
                  rsp_valid, cmd_ready, busy, rsp_last, rsp_data);
      end
      @(negedge clk);
      reset = 1'b0;
      rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({cmd_ready, rsp_valid, model_cnt} !== {2'b10, 8'h00}) begin
         n_fail++;
         $display("FAIL mid_after_release: got ready=%b valid=%b model=%h expected 1 0 00",
                  cmd_ready, rsp_valid, model_cnt);
      end
   endtask

   task automatic test_busy_ignore;
      send_cmd(3'd2, 3'd1, 8'd2, 1'b0);
      n_checks++;
      if (pin_out[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_rstn_held_low: got %b expected 0", pin_out[1]);
      end
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_sel   = 3'd7;
      cmd_stim  = 3'd7;
      cmd_count = 8'd1;
      cmd_reset = 1'b1;
      n_checks++;
      if ({cmd_ready, busy} !== 2'b01) begin
         n_fail++;
         $display("FAIL busy_ready_low: got ready=%b busy=%b expected 0 1", cmd_ready, busy);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      n_checks++;
      if (pin_out[7:1] !== {3'd2, 3'd1, 1'b0}) begin
         n_fail++;
         $display("FAIL busy_pins_unchanged: got %b expected 0100010", pin_out[7:1]);
      end
      get_rsp(8'h00, 1'b0, 6, "busy_rsp1");
      get_rsp(8'h00, 1'b1, 8, "busy_rsp2");
      repeat (5) @(negedge clk);
      n_checks++;
      if ({busy, cmd_ready, pin_out} !== {2'b01, 3'd2, 3'd1, 2'b00}) begin
         n_fail++;
         $display("FAIL busy_idle_hold: got busy=%b ready=%b pin_out=%h expected 0 1 44",
                  busy, cmd_ready, pin_out);
      end
   endtask

   initial begin
      #1;
      test_reset;
      test_reset_sequence;
      test_back_pressure_and_256;
      test_async_reset;
      test_busy_ignore;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
